hilo_mac_unit: RTL and testbench

Parametrised HI/LO multiply-accumulate unit for the datapath. Replaces the single-cycle HI/LO register with a block containing its own iterative shift-add multiplier, signed and unsigned multiply, multiply-add and multiply-subtract, and direct HI/LO writes. Operations are issued with a start/busy/done handshake so the core can stall on `busy`. HI/LO results are exposed continuously to the forwarding/MFHI/MFLO path.

---
 rtl/hilo_pkg.sv | 52 +++++
 rtl/hilo_mac_unit_seq_multiplier.sv | 64 ++++++
 rtl/hilo_mac_unit.sv | 152 +++++++++++++++
 tb/tb_hilo_mac_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_pkg
//  Description : Shared definitions for the HI/LO multiply-accumulate unit:
//                opcode values, FSM state encoding, accumulate-mode encoding
//                and opcode-classification helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package hilo_pkg;

  // Opcodes are held as 32-bit values so that any operand width up to 32
  // bits can be zero-extended and compared without width mismatches.
  localparam int unsigned OP_MULTU = 32'd1;
  localparam int unsigned OP_MULT  = 32'd2;
  localparam int unsigned OP_MTHI  = 32'd17;
  localparam int unsigned OP_MTLO  = 32'd19;
  localparam int unsigned OP_MADD  = 32'd27;
  localparam int unsigned OP_MADDU = 32'd28;
  localparam int unsigned OP_MSUBU = 32'd29;
  localparam int unsigned OP_MSUB  = 32'd30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // How the finished product is merged into the accumulator.
  typedef enum logic [1:0] {
    ACC_SET = 2'd0,
    ACC_ADD = 2'd1,
    ACC_SUB = 2'd2
  } acc_mode_t;

  function automatic logic is_mul_op(input int unsigned op);
    return op inside {OP_MULTU, OP_MULT, OP_MADD, OP_MADDU, OP_MSUBU, OP_MSUB};
  endfunction

  function automatic logic is_signed_op(input int unsigned op);
    return op inside {OP_MULT, OP_MADD, OP_MSUB};
  endfunction

  function automatic acc_mode_t acc_mode(input int unsigned op);
    acc_mode_t m;
    m = ACC_SET;
    if (op inside {OP_MADD, OP_MADDU}) m = ACC_ADD;
    if (op inside {OP_MSUB, OP_MSUBU}) m = ACC_SUB;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_mac_unit_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier
//  Description : Unsigned radix-2 shift-add multiplier. One partial-product
//                step per asserted step_i; result valid after WIDTH steps.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                load_i         - capture operands, clear product and counter
//                step_i         - perform one shift-add step
//                a_i, b_i       - multiplicand / multiplier (unsigned)
//                valid_o        - WIDTH steps completed, prod_o is final
//                last_o         - the next step is the final one
//                prod_o         - 2*WIDTH-bit product
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               valid_o,
  output logic               last_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_CNT_DONE = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mplier_q;  // multiplier, shifted right each step
  logic [2*WIDTH-1:0] prod_q;
  logic [CNT_W-1:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (step_i && (cnt_q != C_CNT_DONE)) begin
      if (mplier_q[0]) begin
        prod_q <= prod_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  assign valid_o = (cnt_q == C_CNT_DONE);
  assign last_o  = (cnt_q == C_CNT_LAST);
  assign prod_o  = prod_q;

endmodule
`default_nettype wire

// File: rtl/hilo_mac_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_mac_unit
//  Description : HI/LO multiply-accumulate unit. Signed/unsigned multiply,
//                multiply-add, multiply-subtract via an iterative shift-add
//                core, plus single-cycle MTHI/MTLO writes.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                start_i, op_i  - issue request and opcode (taken when idle)
//                src_a_i        - multiplicand or MTHI/MTLO data
//                src_b_i        - multiplier
//                busy_o         - multiply in flight, starts are dropped
//                done_o         - one-cycle pulse, HI/LO already updated
//                hi_out_o       - accumulator upper half
//                lo_out_o       - accumulator lower half
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_mac_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_out_o,
  output logic [WIDTH-1:0] lo_out_o
);

  state_t             state_q;
  acc_mode_t          mode_q;
  logic               neg_q;      // product must be negated at writeback
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;

  int unsigned        w_op;
  logic               w_is_mul;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_load;
  logic               w_step;
  logic               w_mul_valid;
  logic               w_mul_last;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_signed;

  assign w_op     = 32'(op_i);
  assign w_is_mul = is_mul_op(w_op);
  assign w_signed = is_signed_op(w_op);

  // Negating the most negative value yields the same bit pattern, which read
  // as unsigned is exactly its magnitude 2^(WIDTH-1).
  assign w_a_neg = w_signed && src_a_i[WIDTH-1];
  assign w_b_neg = w_signed && src_b_i[WIDTH-1];
  assign w_a_mag = w_a_neg ? -src_a_i : src_a_i;
  assign w_b_mag = w_b_neg ? -src_b_i : src_b_i;

  assign w_load = (state_q == ST_IDLE) && start_i && w_is_mul;
  assign w_step = (state_q == ST_MUL);

  seq_multiplier #(
    .WIDTH (WIDTH)
  ) u_mult (
    .clk     (clk),
    .rst     (rst),
    .load_i  (w_load),
    .step_i  (w_step),
    .a_i     (w_a_mag),
    .b_i     (w_b_mag),
    .valid_o (w_mul_valid),
    .last_o  (w_mul_last),
    .prod_o  (w_prod)
  );

  assign w_prod_signed = neg_q ? -w_prod : w_prod;

  always_comb begin
    acc_d = acc_q;
    case (mode_q)
      ACC_SET: acc_d = w_prod_signed;
      ACC_ADD: acc_d = acc_q + w_prod_signed;
      ACC_SUB: acc_d = acc_q - w_prod_signed;
      default: acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= ACC_SET;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      acc_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (w_is_mul) begin
              state_q <= ST_MUL;
              busy_q  <= 1'b1;
              mode_q  <= acc_mode(w_op);
              neg_q   <= w_a_neg ^ w_b_neg;
            end else if (w_op == OP_MTHI) begin
              acc_q[2*WIDTH-1:WIDTH] <= src_a_i;
              done_q                 <= 1'b1;
            end else if (w_op == OP_MTLO) begin
              acc_q[WIDTH-1:0] <= src_a_i;
              done_q           <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          // The step taken on this edge is the final one.
          if (w_mul_last) begin
            state_q <= ST_WB;
          end
        end
        ST_WB: begin
          if (w_mul_valid) begin
            acc_q <= acc_d;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign hi_out_o = acc_q[2*WIDTH-1:WIDTH];
  assign lo_out_o = acc_q[WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_hilo_mac_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_mac_unit
//  Description : Scoreboard bench for hilo_mac_unit with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hilo_mac_unit;

  localparam int WIDTH = 32;
  localparam int OP_W  = 6;

  localparam int unsigned C_MULTU = 1;
  localparam int unsigned C_MULT  = 2;
  localparam int unsigned C_MTHI  = 17;
  localparam int unsigned C_MTLO  = 19;
  localparam int unsigned C_MADD  = 27;
  localparam int unsigned C_MADDU = 28;
  localparam int unsigned C_MSUBU = 29;
  localparam int unsigned C_MSUB  = 30;

  logic             clk;
  logic             rst;
  logic             start_i;
  logic [OP_W-1:0]  op_i;
  logic [WIDTH-1:0] src_a_i;
  logic [WIDTH-1:0] src_b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_out_o;
  logic [WIDTH-1:0] lo_out_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  hilo_mac_unit #(
    .WIDTH (WIDTH),
    .OP_W  (OP_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .src_a_i  (src_a_i),
    .src_b_i  (src_b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .hi_out_o (hi_out_o),
    .lo_out_o (lo_out_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && done_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got HI/LO 0x%h%h, expected no done", hi_out_o, lo_out_o);
        end else begin
          check("hilo_result", {hi_out_o, lo_out_o}, exp_q.pop_front());
        end
      end
    end
  end

  // Issue one operation (called at a negedge) and wait for its done pulse,
  // checking latency and busy duration. Returns at the negedge showing done.
  task automatic run_op(input int unsigned op, input logic [31:0] a, input logic [31:0] b,
                        input bit is_mul, input logic [63:0] exp);
    int cyc;
    int busy_cnt;
    exp_q.push_back(exp);
    start_i = 1'b1;
    op_i    = op[5:0];
    src_a_i = a;
    src_b_i = b;
    @(posedge clk);
    #1 start_i = 1'b0;
    cyc      = 0;
    busy_cnt = 0;
    @(negedge clk);
    cyc++;
    while (!done_o && cyc < 100) begin
      if (busy_o) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    if (!done_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done", cyc);
    end else begin
      check("done_latency", 64'(cyc), is_mul ? 64'd34 : 64'd1);
      check("busy_cycles", 64'(busy_cnt), is_mul ? 64'd33 : 64'd0);
      check("busy_at_done", 64'(busy_o), 64'd0);
    end
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (!done_o && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!done_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no done in %0d cycles, expected done", name, cyc);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    op_i    = '0;
    src_a_i = '0;
    src_b_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_hilo", {hi_out_o, lo_out_o}, 64'h0);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_done", 64'(done_o), 64'd0);

    // Multiply-class and move operations, issued back to back.
    run_op(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
    run_op(C_MULT,  32'hFFFF_FFFD, 32'd5,         1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(C_MADD,  32'h8000_0000, 32'h8000_0000, 1'b1, 64'h3FFF_FFFF_FFFF_FFF1);
    run_op(C_MTHI,  32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 64'h1234_5678_FFFF_FFF1);
    run_op(C_MTLO,  32'h9ABC_DEF0, 32'hDEAD_BEEF, 1'b0, 64'h1234_5678_9ABC_DEF0);
    run_op(C_MSUBU, 32'd2,         32'd3,         1'b1, 64'h1234_5678_9ABC_DEEA);
    run_op(C_MTLO,  32'hFFFF_FFF8, 32'h0,         1'b0, 64'h1234_5678_FFFF_FFF8);
    run_op(C_MADDU, 32'd1,         32'h10,        1'b1, 64'h1234_5679_0000_0008);
    run_op(C_MSUB,  32'hFFFF_FFFF, 32'd1,         1'b1, 64'h1234_5679_0000_0009);
    run_op(C_MULT,  32'h8000_0000, 32'd1,         1'b1, 64'hFFFF_FFFF_8000_0000);
    run_op(C_MULT,  32'd7,         32'hFFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2);
    repeat (2) @(negedge clk);

    // A start while busy is dropped; a start in the done cycle is accepted.
    exp_q.push_back(64'd6);
    start_i = 1'b1;
    op_i    = 6'd1;
    src_a_i = 32'd2;
    src_b_i = 32'd3;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_mid_op", 64'(busy_o), 64'd1);
    start_i = 1'b1;
    op_i    = 6'd1;
    src_a_i = 32'd7;
    src_b_i = 32'd7;
    @(posedge clk);
    #1 start_i = 1'b0;
    @(negedge clk);
    wait_done("dropped_start_done");
    run_op(C_MULTU, 32'd3, 32'd4, 1'b1, 64'd12);
    repeat (5) @(negedge clk);

    // Reset in the middle of a multiply discards it.
    start_i = 1'b1;
    op_i    = 6'd1;
    src_a_i = 32'd5;
    src_b_i = 32'd5;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_before_rst", 64'(busy_o), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_done", 64'(done_o), 64'd0);
    check("rst_mid_hilo", {hi_out_o, lo_out_o}, 64'h0);
    repeat (40) @(negedge clk);

    // Unknown opcode leaves everything untouched.
    run_op(C_MTLO, 32'h0000_0055, 32'h0, 1'b0, 64'h0000_0000_0000_0055);
    start_i = 1'b1;
    op_i    = 6'd5;
    src_a_i = 32'h0000_AAAA;
    src_b_i = 32'h0000_0003;
    @(posedge clk);
    #1 start_i = 1'b0;
    @(negedge clk);
    check("unknown_busy", 64'(busy_o), 64'd0);
    repeat (5) @(negedge clk);
    check("unknown_hilo", {hi_out_o, lo_out_o}, 64'h0000_0000_0000_0055);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
